asp_ingress_scheduler: RTL and testbench
========================================

// Module: asp_ingress_scheduler
// PURPOSE
//  Two-way scheduler in front of the stage-2 pipeline register. Arbitrates host TX words (data+parity) and network RX words (data+tag).
//  Checks TX parity and emits one opcode-tagged op per cycle into a 1-entry output register, using valid/ready handshakes.
//  Halts TX after repeated parity errors until software clears the condition.
// PARAMETERS
//  data_size  32  payload width
//  tag_size   8   network tag width
//  ERR_LIMIT  4   consecutive TX parity errors that force HALT (1..255)
// PORTS
//  clk             in   1                 single clock, rising edge
//  reset_n         in   1                 asynchronous, active-low reset
//  tx_valid        in   1                 host word offered
//  tx_ready        out  1                 host word accepted this cycle
//  tx_dpp          in   data_size+1       {data, parity}; parity in bit 0
//  rx_valid        in   1                 network word offered
//  rx_ready        out  1                 network word accepted this cycle
//  rx_ndt          in   data_size+tag_size  {data, tag}; tag in low bits
//  out_valid       out  1                 output register holds an op
//  out_ready       in   1                 downstream consumes op
//  opcode_out      out  2                 NOP=00, RX=01, TX=10, 11 reserved/never issued
//  soft_error_out  out  1                 TX op failed parity
//  dpp_out         out  data_size+1       TX payload; zero on RX ops
//  ndt_out         out  data_size+tag_size  RX payload; zero on TX ops
//  err_clear       in   1                 1-cycle pulse; clears HALT and counters
//  halted          out  1                 state == HALT
//  err_count       out  8                 total TX parity errors, saturates at 255
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - All outputs 0; opcode_out=NOP; state RUN.
//   - Round-robin pointer set to TX-first; counters 0.
//   - Any in-flight op is discarded.
//  Load enable:
//   - load = !out_valid || out_ready.
//   - tx_ready/rx_ready may be 1 only when load is 1.
//  Arbitration:
//   - Eligible TX: tx_valid && state==RUN. Eligible RX: rx_valid.
//   - One eligible requester: it wins.
//   - Both eligible: the side not granted last wins.
//   - The pointer updates only on an actual grant.
//   - ready = load && win (combinational from valids).
//   - Sources must not make valid depend on ready.
//  Latency:
//   - An accepted word appears in the output register on the next edge, with out_valid=1.
//   - TX op: opcode=TX, dpp_out=tx_dpp, ndt_out=0.
//   - RX op: opcode=RX, ndt_out=rx_ndt, dpp_out=0, soft_error=0.
//  Output register:
//   - Stall (out_valid && !out_ready): the register holds all fields unchanged.
//   - Pop with no new grant: out_valid=0, opcode=NOP, soft_error=0; payloads hold.
//  Parity:
//   - Even parity; error when ^tx_dpp == 1.
//   - An erroring word is still issued, with soft_error_out=1.
//  Error counters:
//   - consec_err increments on each erroring TX grant; resets to 0 on a clean TX grant.
//   - RX grants do not affect consec_err.
//   - err_count increments on each erroring TX grant and saturates at 255.
//  FSM RUN/HALT:
//   - RUN->HALT on the edge where consec_err reaches ERR_LIMIT. The erroring op is still issued.
//   - In HALT: tx_ready=0 and the TX word is held by the source; RX continues at full rate.
//   - HALT->RUN on err_clear.
//  err_clear:
//   - Zeroes consec_err and err_count.
//   - Has priority over a same-cycle error increment.
//   - The op granted in that cycle is still issued with its soft_error flag.
// STRUCTURE
//  Package asp_pkg:
//   - OP_NOP/OP_RX/OP_TX localparams; RUN/HALT state encodings.
//   - Opcode bit 0 is the RX/TX select.
//  Sub-module asp_rr_arb2: 2-request round-robin arbiter (req[1:0], advance -> gnt[1:0]).
//  Parity check, counters, FSM and output register are in the top-level module.
// TESTING
//  1. TX only, tx_dpp={32'h0000_0003,1'b0}, out_ready=1
//     -> next cycle opcode=10, soft_error=0, ndt_out=0, 1 op/cycle.
//  2. tx_valid=rx_valid=1 continuously, out_ready=1
//     -> opcodes alternate 10,01,10,01..., TX first after reset.
//  3. out_ready=0 for 3 cycles with an op held
//     -> all outputs stable; tx_ready=rx_ready=0; op released when out_ready=1.
//  4. 4 TX words with bad parity
//     -> 4 ops with soft_error=1; halted=1 after the 4th; err_count=4.
//     -> Then TX blocked while RX still issues. err_clear -> halted=0, err_count=0, TX resumes.
//  5. 3 bad, 1 good, 3 bad TX words -> no HALT; err_count=6.
//  6. Assert reset_n low mid-stall with out_valid=1
//     -> out_valid=0, opcode=NOP immediately (async).
//     -> After release, TX wins the first contested grant.

Source files
------------

// File: rtl/asp_ingress_scheduler_pkg.sv
// Shared opcodes and FSM encodings for the ingress scheduler.
package asp_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RX  = 2'b01;
    localparam logic [1:0] OP_TX  = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Bit 0 of an issued opcode selects RX (1) versus TX (0).
    function automatic logic op_is_rx(input logic [1:0] op);
        op_is_rx = op[0];
    endfunction

endpackage

// File: rtl/asp_ingress_scheduler_if.sv
// Handshake bundle between host/network sources, the scheduler and the stage-2 consumer.
interface asp_ingress_scheduler_if #(
    parameter int data_size = 32,
    parameter int tag_size  = 8
);
    logic                          tx_valid;
    logic                          tx_ready;
    logic [data_size:0]            tx_dpp;
    logic                          rx_valid;
    logic                          rx_ready;
    logic [data_size+tag_size-1:0] rx_ndt;
    logic                          out_valid;
    logic                          out_ready;
    logic [1:0]                    opcode_out;
    logic                          soft_error_out;
    logic [data_size:0]            dpp_out;
    logic [data_size+tag_size-1:0] ndt_out;

    modport slave (
        input  tx_valid, tx_dpp, rx_valid, rx_ndt, out_ready,
        output tx_ready, rx_ready, out_valid, opcode_out, soft_error_out, dpp_out, ndt_out
    );

    modport master (
        output tx_valid, tx_dpp, rx_valid, rx_ndt, out_ready,
        input  tx_ready, rx_ready, out_valid, opcode_out, soft_error_out, dpp_out, ndt_out
    );
endinterface

// File: rtl/asp_ingress_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; index 0 is TX, index 1 is RX.
module asp_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_r;

    // Grant selection; on contention the side not granted last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer remembers the last granted side; reset pretends RX went last so TX goes first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/asp_ingress_scheduler.sv
// Ingress scheduler: arbitrates TX/RX words into a one-entry op register, checks TX parity, halts TX on error bursts.
module asp_ingress_scheduler
    import asp_pkg::*;
#(
    parameter int data_size = 32,
    parameter int tag_size  = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    asp_ingress_scheduler_if.slave  bus,
    input  logic                    err_clear,
    output logic                    halted,
    output logic [7:0]              err_count
);

    localparam int         DPP_W   = data_size + 1;
    localparam int         NDT_W   = data_size + tag_size;
    localparam logic [7:0] LIMIT_C = 8'(ERR_LIMIT);

    function automatic logic parity_odd(input logic [DPP_W-1:0] w);
        parity_odd = ^w;
    endfunction

    state_e             state_r;
    logic [7:0]         consec_r;
    logic [7:0]         err_count_r;
    logic               out_valid_r;
    logic [1:0]         opcode_r;
    logic               soft_error_r;
    logic [DPP_W-1:0]   dpp_r;
    logic [NDT_W-1:0]   ndt_r;

    logic               load_s;
    logic [1:0]         req_s;
    logic [1:0]         gnt_s;
    logic               tx_take_s;
    logic               rx_take_s;
    logic               perr_s;
    logic [7:0]         consec_inc_s;

    assign load_s       = !out_valid_r || bus.out_ready;
    assign req_s        = {bus.rx_valid, bus.tx_valid && (state_r == ST_RUN)};
    assign tx_take_s    = load_s && gnt_s[0];
    assign rx_take_s    = load_s && gnt_s[1];
    assign perr_s       = parity_odd(bus.tx_dpp);
    assign consec_inc_s = consec_r + 8'd1;

    asp_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_s),
        .advance (load_s),
        .gnt     (gnt_s)
    );

    // Output op register: load on grant, drop to NOP on an empty pop, hold on stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r  <= 1'b0;
            opcode_r     <= OP_NOP;
            soft_error_r <= 1'b0;
            dpp_r        <= '0;
            ndt_r        <= '0;
        end else if (tx_take_s) begin
            out_valid_r  <= 1'b1;
            opcode_r     <= OP_TX;
            soft_error_r <= perr_s;
            dpp_r        <= bus.tx_dpp;
            ndt_r        <= '0;
        end else if (rx_take_s) begin
            out_valid_r  <= 1'b1;
            opcode_r     <= OP_RX;
            soft_error_r <= 1'b0;
            dpp_r        <= '0;
            ndt_r        <= bus.rx_ndt;
        end else if (load_s) begin
            out_valid_r  <= 1'b0;
            opcode_r     <= OP_NOP;
            soft_error_r <= 1'b0;
            dpp_r        <= dpp_r;
            ndt_r        <= ndt_r;
        end else begin
            out_valid_r  <= out_valid_r;
            opcode_r     <= opcode_r;
            soft_error_r <= soft_error_r;
            dpp_r        <= dpp_r;
            ndt_r        <= ndt_r;
        end
    end

    // RUN/HALT FSM with error counters; err_clear beats any same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            consec_r    <= 8'd0;
            err_count_r <= 8'd0;
        end else if (err_clear) begin
            state_r     <= ST_RUN;
            consec_r    <= 8'd0;
            err_count_r <= 8'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (tx_take_s && perr_s) begin
                        consec_r    <= consec_inc_s;
                        err_count_r <= (err_count_r == 8'd255) ? 8'd255 : err_count_r + 8'd1;
                        state_r     <= (consec_inc_s == LIMIT_C) ? ST_HALT : ST_RUN;
                    end else if (tx_take_s) begin
                        consec_r    <= 8'd0;
                        err_count_r <= err_count_r;
                        state_r     <= ST_RUN;
                    end else begin
                        consec_r    <= consec_r;
                        err_count_r <= err_count_r;
                        state_r     <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    consec_r    <= consec_r;
                    err_count_r <= err_count_r;
                    state_r     <= ST_HALT;
                end
                default: begin
                    consec_r    <= 8'd0;
                    err_count_r <= err_count_r;
                    state_r     <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.tx_ready       = tx_take_s;
    assign bus.rx_ready       = rx_take_s;
    assign bus.out_valid      = out_valid_r;
    assign bus.opcode_out     = opcode_r;
    assign bus.soft_error_out = soft_error_r;
    assign bus.dpp_out        = dpp_r;
    assign bus.ndt_out        = ndt_r;
    assign halted             = (state_r == ST_HALT);
    assign err_count          = err_count_r;

endmodule

// File: tb/tb_asp_ingress_scheduler.sv
// Directed bench for asp_ingress_scheduler with a cycle-level reference model and literal spot checks.
module tb_asp_ingress_scheduler;

    localparam int DS = 32;
    localparam int TS = 8;
    localparam int LIM = 4;

    logic       clk;
    logic       reset_n;
    logic       err_clear;
    logic       halted;
    logic [7:0] err_count;

    asp_ingress_scheduler_if #(.data_size(DS), .tag_size(TS)) bus ();

    asp_ingress_scheduler #(.data_size(DS), .tag_size(TS), .ERR_LIMIT(LIM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_clear (err_clear),
        .halted    (halted),
        .err_count (err_count)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Build a TX word whose total ones-count is even (clean) or odd (bad).
    function automatic logic [DS:0] mk_tx(input logic [DS-1:0] d, input bit bad);
        logic p;
        p = (^d) ^ bad;
        return {d, p};
    endfunction

    // Reference model: what the op register and counters must hold.
    bit              m_valid, m_serr, m_halt, m_last_rx;
    logic [1:0]      m_op;
    logic [DS:0]     m_dpp;
    logic [DS+TS-1:0] m_ndt;
    int              m_consec, m_errs;

    function automatic bit m_can_load();
        return !m_valid || (bus.out_ready === 1'b1);
    endfunction
    function automatic bit m_tx_wins();
        bit te, re;
        te = (bus.tx_valid === 1'b1) && !m_halt;
        re = (bus.rx_valid === 1'b1);
        return m_can_load() && te && (!re || m_last_rx);
    endfunction
    function automatic bit m_rx_wins();
        bit te, re;
        te = (bus.tx_valid === 1'b1) && !m_halt;
        re = (bus.rx_valid === 1'b1);
        return m_can_load() && re && (!te || !m_last_rx);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_valid = 0; m_serr = 0; m_halt = 0; m_last_rx = 1;
                m_op = 2'b00; m_dpp = '0; m_ndt = '0; m_consec = 0; m_errs = 0;
            end else begin
                bit gt, gr, bad;
                gt  = m_tx_wins();
                gr  = m_rx_wins();
                bad = ($countones(bus.tx_dpp) % 2) == 1;
                if (gt) begin
                    m_valid = 1; m_op = 2'b10; m_dpp = bus.tx_dpp; m_ndt = '0; m_serr = bad; m_last_rx = 0;
                end else if (gr) begin
                    m_valid = 1; m_op = 2'b01; m_dpp = '0; m_ndt = bus.rx_ndt; m_serr = 0; m_last_rx = 1;
                end else if (m_can_load()) begin
                    m_valid = 0; m_op = 2'b00; m_serr = 0;
                end
                if (err_clear) begin
                    m_consec = 0; m_errs = 0; m_halt = 0;
                end else if (gt && bad) begin
                    m_consec++;
                    if (m_errs < 255) m_errs++;
                    if (m_consec == LIM) m_halt = 1;
                end else if (gt) begin
                    m_consec = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                check("tx_ready",   64'(bus.tx_ready),       64'(m_tx_wins()));
                check("rx_ready",   64'(bus.rx_ready),       64'(m_rx_wins()));
                check("out_valid",  64'(bus.out_valid),      64'(m_valid));
                check("opcode",     64'(bus.opcode_out),     64'(m_op));
                check("soft_error", 64'(bus.soft_error_out), 64'(m_serr));
                check("dpp_out",    64'(bus.dpp_out),        64'(m_dpp));
                check("ndt_out",    64'(bus.ndt_out),        64'(m_ndt));
                check("halted",     64'(halted),             64'(m_halt));
                check("err_count",  64'(err_count),          64'(m_errs));
            end
        end
    end

    task automatic cyc(input bit tv, input logic [DS:0] td, input bit rv,
                       input logic [DS+TS-1:0] rd, input bit ordy, input bit clr);
        bus.tx_valid  = tv;
        bus.tx_dpp    = td;
        bus.rx_valid  = rv;
        bus.rx_ndt    = rd;
        bus.out_ready = ordy;
        err_clear     = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DS:0] held;
        logic [1:0]  seq [4];
        reset_n = 1'b0; err_clear = 1'b0;
        bus.tx_valid = 1'b0; bus.tx_dpp = '0; bus.rx_valid = 1'b0; bus.rx_ndt = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_opcode",    64'(bus.opcode_out), 64'd0);
        check("rst_halted",    64'(halted), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        reset_n = 1'b1;

        // Contested grants alternate, TX first after reset.
        seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            cyc(1, mk_tx(32'h100 + i, 0), 1, 40'hAB_0000_0000 + 40'(i), 1, 0);
            check("rr_opcode", 64'(bus.opcode_out), 64'(seq[i]));
        end

        // TX only, one op per cycle.
        for (int i = 0; i < 3; i++) begin
            cyc(1, mk_tx(32'h0000_0003, 0), 0, '0, 1, 0);
            check("tx_opcode", 64'(bus.opcode_out), 64'h2);
            check("tx_serr",   64'(bus.soft_error_out), 64'h0);
            check("tx_ndt",    64'(bus.ndt_out), 64'h0);
            check("tx_dpp",    64'(bus.dpp_out), 64'h6);
        end

        // Stall holds the register and blocks both sources.
        held = mk_tx(32'hA5, 0);
        cyc(1, held, 0, '0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, mk_tx(32'h77, 0), 1, 40'h12_3456_7890, 0, 0);
            check("stall_dpp",      64'(bus.dpp_out), 64'(held));
            check("stall_valid",    64'(bus.out_valid), 64'h1);
            check("stall_tx_ready", 64'(bus.tx_ready), 64'h0);
            check("stall_rx_ready", 64'(bus.rx_ready), 64'h0);
        end
        cyc(1, mk_tx(32'h77, 0), 1, 40'h12_3456_7890, 1, 0);
        check("release_opcode", 64'(bus.opcode_out), 64'h1);
        cyc(0, '0, 0, '0, 1, 0);
        check("drain_valid", 64'(bus.out_valid), 64'h0);

        // Four bad TX words force HALT.
        for (int i = 0; i < 4; i++) begin
            cyc(1, mk_tx(32'h1 + i, 1), 0, '0, 1, 0);
            check("bad_serr",   64'(bus.soft_error_out), 64'h1);
            check("bad_opcode", 64'(bus.opcode_out), 64'h2);
            check("bad_halted", 64'(halted), (i == 3) ? 64'h1 : 64'h0);
        end
        check("halt_err_count", 64'(err_count), 64'd4);
        for (int i = 0; i < 2; i++) begin
            cyc(1, mk_tx(32'h9, 1), 1, 40'h55_0000_0000 + 40'(i), 1, 0);
            check("halt_rx_opcode", 64'(bus.opcode_out), 64'h1);
        end
        cyc(1, mk_tx(32'h9, 1), 0, '0, 1, 1);
        check("clr_halted",    64'(halted), 64'h0);
        check("clr_err_count", 64'(err_count), 64'd0);
        cyc(1, mk_tx(32'h11, 0), 0, '0, 1, 0);
        check("resume_opcode", 64'(bus.opcode_out), 64'h2);

        // 3 bad, 1 good, 3 bad: no HALT, six errors counted.
        for (int i = 0; i < 7; i++)
            cyc(1, mk_tx(32'h40 + i, i != 3), 0, '0, 1, 0);
        check("mix_err_count", 64'(err_count), 64'd6);
        check("mix_halted",    64'(halted), 64'h0);

        // Async reset in the middle of a stall.
        cyc(1, mk_tx(32'h22, 0), 0, '0, 1, 0);
        cyc(1, mk_tx(32'h33, 0), 1, 40'h77, 0, 0);
        check("pre_rst_valid", 64'(bus.out_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid",  64'(bus.out_valid), 64'h0);
        check("async_opcode", 64'(bus.opcode_out), 64'h0);
        check("async_errs",   64'(err_count), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1, mk_tx(32'h44, 0), 1, 40'h88, 1, 0);
        check("post_rst_opcode", 64'(bus.opcode_out), 64'h2);
        cyc(1, mk_tx(32'h45, 0), 1, 40'h89, 1, 0);
        check("post_rst_rx", 64'(bus.opcode_out), 64'h1);
        cyc(0, '0, 0, '0, 1, 0);
        cyc(0, '0, 0, '0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
